// File: rtl/axis_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : axis_req_arbiter
//  Purpose  : Round-robin, burst-locking arbiter that shares one AXI-Stream
//             sink among NUM_REQ requester streams. A grant is held until the
//             granted requester's tlast beat, or until MAX_BURST beats have
//             transferred, and then re-arbitration starts from the requester
//             after the one just served. req_en_i masks requesters out of
//             arbitration.
//  Ports    : clk_i, arstn_i          clock, asynchronous active-low reset
//             req_en_i                per-requester arbitration enable
//             s_tdata_i/tvalid_i/tlast_i, s_tready_o   requester streams
//             m_tdata_o/tvalid_o/tlast_o, m_tready_i   shared sink stream
//             grant_o                 one-hot registered grant (0 when idle)
//             busy_o                  high while a grant is held
//  Revision : 1.0  initial release
// ============================================================================
module axis_req_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_BURST  = 8
) (
    input  logic                          clk_i,
    input  logic                          arstn_i,
    input  logic [NUM_REQ-1:0]            req_en_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] s_tdata_i,
    input  logic [NUM_REQ-1:0]            s_tvalid_i,
    input  logic [NUM_REQ-1:0]            s_tlast_i,
    output logic [NUM_REQ-1:0]            s_tready_o,
    output logic [DATA_WIDTH-1:0]         m_tdata_o,
    output logic                          m_tvalid_o,
    output logic                          m_tlast_o,
    input  logic                          m_tready_i,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic                          busy_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    localparam logic [0:0] ST_ARB   = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
    localparam logic [IDX_W-1:0] PTR_RST   = IDX_W'(NUM_REQ - 1);

    logic [0:0]         state_q,    state_d;
    logic [IDX_W-1:0]   last_ptr_q, last_ptr_d;
    logic [IDX_W-1:0]   g_q,        g_d;
    logic [NUM_REQ-1:0] grant_q,    grant_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;

    logic [NUM_REQ-1:0] eligible;
    logic               sel_found;
    logic [IDX_W-1:0]   sel_idx;
    logic [IDX_W-1:0]   cand;
    logic               beat;

    assign eligible = s_tvalid_i & req_en_i;

    // Scan upward from last_ptr+1, wrapping; the last candidate examined is
    // last_ptr itself, so a lone eligible requester can be re-granted.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(last_ptr_q) + k) % NUM_REQ);
            if (!sel_found && eligible[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // Combinational pass-through from the granted requester while in GRANT;
    // everything is held at zero in ARB.
    always_comb begin
        m_tdata_o  = '0;
        m_tvalid_o = 1'b0;
        m_tlast_o  = 1'b0;
        s_tready_o = '0;
        if (state_q == ST_GRANT) begin
            m_tdata_o  = s_tdata_i[int'(g_q)*DATA_WIDTH +: DATA_WIDTH];
            m_tvalid_o = s_tvalid_i[g_q];
            // Forced tlast on the MAX_BURST-th beat bounds the burst length
            // and keeps beat_cnt from overflowing.
            m_tlast_o  = s_tlast_i[g_q] | (beat_cnt_q == LAST_BEAT);
            s_tready_o = grant_q & {NUM_REQ{m_tready_i}};
        end
    end

    assign beat    = m_tvalid_o & m_tready_i;
    assign grant_o = grant_q;
    assign busy_o  = (state_q == ST_GRANT);

    always_comb begin
        state_d    = state_q;
        last_ptr_d = last_ptr_q;
        g_d        = g_q;
        grant_d    = grant_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            ST_ARB: begin
                if (sel_found) begin
                    g_d        = sel_idx;
                    grant_d    = NUM_REQ'(1) << sel_idx;
                    beat_cnt_d = '0;
                    state_d    = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (beat) begin
                    if (m_tlast_o) begin
                        last_ptr_d = g_q;
                        grant_d    = '0;
                        beat_cnt_d = '0;
                        state_d    = ST_ARB;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                grant_d = '0;
                state_d = ST_ARB;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q    <= ST_ARB;
            last_ptr_q <= PTR_RST;
            g_q        <= '0;
            grant_q    <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            last_ptr_q <= last_ptr_d;
            g_q        <= g_d;
            grant_q    <= grant_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axis_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axis_req_arbiter
//  Purpose  : Self-checking bench for axis_req_arbiter. Directed scenarios
//             followed by randomized traffic, every cycle compared against a
//             transaction-level round-robin reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_axis_req_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int MB = 8;

    logic              clk_i = 1'b0;
    logic              arstn_i;
    logic [N-1:0]      req_en_i;
    logic [N*DW-1:0]   s_tdata_i;
    logic [N-1:0]      s_tvalid_i;
    logic [N-1:0]      s_tlast_i;
    logic [N-1:0]      s_tready_o;
    logic [DW-1:0]     m_tdata_o;
    logic              m_tvalid_o;
    logic              m_tlast_o;
    logic              m_tready_i;
    logic [N-1:0]      grant_o;
    logic              busy_o;

    axis_req_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB)
    ) dut (
        .clk_i      (clk_i),
        .arstn_i    (arstn_i),
        .req_en_i   (req_en_i),
        .s_tdata_i  (s_tdata_i),
        .s_tvalid_i (s_tvalid_i),
        .s_tlast_i  (s_tlast_i),
        .s_tready_o (s_tready_o),
        .m_tdata_o  (m_tdata_o),
        .m_tvalid_o (m_tvalid_o),
        .m_tlast_o  (m_tlast_o),
        .m_tready_i (m_tready_i),
        .grant_o    (grant_o),
        .busy_o     (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: who holds the sink, how many beats it has moved,
    // and which requester was served last.
    bit mdl_busy  = 1'b0;
    int mdl_g     = 0;
    int mdl_beats = 0;
    int mdl_last  = N - 1;

    // Called just after a falling edge with inputs already driven: checks
    // outputs for this cycle, then advances the model across the rising edge.
    task automatic step();
        logic [DW-1:0] e_data;
        logic          e_valid, e_last;
        logic [N-1:0]  e_ready, e_grant;
        bit            nx_busy;
        int            nx_g, nx_beats, nx_last;
        #1;
        if (!arstn_i) begin
            mdl_busy  = 1'b0;
            mdl_g     = 0;
            mdl_beats = 0;
            mdl_last  = N - 1;
        end
        e_data  = '0;
        e_valid = 1'b0;
        e_last  = 1'b0;
        e_ready = '0;
        e_grant = '0;
        if (mdl_busy) begin
            e_data  = s_tdata_i[mdl_g*DW +: DW];
            e_valid = s_tvalid_i[mdl_g];
            e_last  = s_tlast_i[mdl_g] || (mdl_beats == MB - 1);
            e_ready[mdl_g] = m_tready_i;
            e_grant[mdl_g] = 1'b1;
        end
        chk("m_tvalid", m_tvalid_o, e_valid);
        chk("m_tlast",  m_tlast_o,  e_last);
        chk("s_tready", s_tready_o, e_ready);
        chk("grant",    grant_o,    e_grant);
        chk("busy",     busy_o,     mdl_busy);
        if (e_valid || !arstn_i)
            chk("m_tdata", m_tdata_o, e_data);

        nx_busy  = mdl_busy;
        nx_g     = mdl_g;
        nx_beats = mdl_beats;
        nx_last  = mdl_last;
        if (arstn_i) begin
            if (!mdl_busy) begin
                for (int k = 1; k <= N; k++) begin
                    int c;
                    c = (mdl_last + k) % N;
                    if (s_tvalid_i[c] && req_en_i[c]) begin
                        nx_busy  = 1'b1;
                        nx_g     = c;
                        nx_beats = 0;
                        break;
                    end
                end
            end else if (e_valid && m_tready_i) begin
                if (e_last) begin
                    nx_busy = 1'b0;
                    nx_last = mdl_g;
                end else begin
                    nx_beats = mdl_beats + 1;
                end
            end
        end
        @(posedge clk_i);
        mdl_busy  = nx_busy;
        mdl_g     = nx_g;
        mdl_beats = nx_beats;
        mdl_last  = nx_last;
        @(negedge clk_i);
    endtask

    task automatic clr();
        s_tdata_i  = '0;
        s_tvalid_i = '0;
        s_tlast_i  = '0;
        req_en_i   = '1;
        m_tready_i = 1'b1;
    endtask

    task automatic set_req(input int k, input logic v, input logic [DW-1:0] d, input logic l);
        s_tvalid_i[k]         = v;
        s_tdata_i[k*DW +: DW] = d;
        s_tlast_i[k]          = l;
    endtask

    task automatic do_reset();
        clr();
        arstn_i = 1'b0;
        step();
        step();
        arstn_i = 1'b1;
    endtask

    initial begin
        arstn_i = 1'b0;
        clr();
        @(negedge clk_i);
        do_reset();

        // Single requester 2, three-beat burst.
        set_req(2, 1'b1, 16'h0A01, 1'b0);
        step();
        chk("t1_grant", grant_o, 4'b0100);
        step();
        set_req(2, 1'b1, 16'h0A02, 1'b0);
        step();
        set_req(2, 1'b1, 16'h0A03, 1'b1);
        step();
        clr();
        step();
        chk("t1_idle", grant_o, 4'b0000);

        // All requesters valid, single-beat bursts: 0,1,2,3,0 with bubbles.
        do_reset();
        for (int k = 0; k < N; k++) set_req(k, 1'b1, DW'(16'h1000 + k), 1'b1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t2_order", grant_o, 64'(1 << (i % N)));
            step();
        end

        // Requester 1 never asserts tlast: forced release after MAX_BURST.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            set_req(1, 1'b1, DW'($urandom), 1'b0);
            step();
        end
        for (int i = 0; i < 24; i++) begin
            set_req(1, 1'b1, DW'($urandom), 1'b0);
            set_req(2, 1'b1, DW'($urandom), 1'b0);
            step();
        end

        // Mask excludes requester 0; unmasking mid-burst does not preempt.
        do_reset();
        req_en_i = 4'b1110;
        set_req(0, 1'b1, 16'h00AA, 1'b0);
        set_req(3, 1'b1, 16'h33BB, 1'b0);
        step();
        chk("t4_grant3", grant_o, 4'b1000);
        for (int i = 0; i < 3; i++) step();
        req_en_i = 4'b1111;
        step();
        step();
        chk("t4_nopreempt", grant_o, 4'b1000);
        set_req(3, 1'b1, 16'h33BC, 1'b1);
        step();
        set_req(3, 1'b1, 16'h33BD, 1'b0);
        step();
        chk("t4_grant0", grant_o, 4'b0001);

        // Backpressure on a four-beat burst from requester 0.
        do_reset();
        for (int k = 1; k < N; k++) set_req(k, 1'b1, DW'(16'h5000 + k), 1'b0);
        for (int i = 0; i < 12; i++) begin
            m_tready_i = (i % 2 == 0);
            set_req(0, 1'b1, DW'(16'h0B00 + i), (mdl_busy && mdl_g == 0 && mdl_beats == 3));
            step();
        end

        // Reset in the middle of a burst from requester 1.
        do_reset();
        set_req(1, 1'b1, 16'h0C01, 1'b0);
        step();
        step();
        set_req(1, 1'b1, 16'h0C02, 1'b0);
        step();
        arstn_i = 1'b0;
        step();
        chk("t6_rst_grant", grant_o, 4'b0000);
        arstn_i = 1'b1;
        set_req(0, 1'b1, 16'h0D01, 1'b0);
        step();
        chk("t6_grant0", grant_o, 4'b0001);

        // Randomized traffic with occasional asynchronous resets.
        clr();
        for (int i = 0; i < 3000; i++) begin
            arstn_i    = ($urandom_range(0, 299) != 0);
            req_en_i   = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
            m_tready_i = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < N; k++)
                set_req(k, ($urandom_range(0, 2) != 0), DW'($urandom),
                        ($urandom_range(0, 4) == 0));
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
